// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential ALU stage that feeds the Z register:
//   opcode encodings, FSM state encoding, flag bit positions and a small
//   helper that packs the four status flags.
//   No ports; imported by alu_seq and alu_seq_mul_shift_add.
package alu_seq_pkg;

  // Default datapath width (bus, operands, result)
  localparam int DATA_W = 16;

  // Flag bit positions inside the 4-bit {N,Z,C,V} flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes 12..15 have no enum member; they fall through to PASSB behaviour
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL1  = 4'd6,
    OP_SHR1  = 4'd7,
    OP_SHLN  = 4'd8,
    OP_SHRN  = 4'd9,
    OP_MUL   = 4'd10,
    OP_PASSB = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FINISH
  } state_e;

  // Packs individual flag bits into the {N,Z,C,V} word
  function automatic logic [3:0] makeFlags(input logic neg, input logic zero,
                                           input logic carry, input logic ovf);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = neg;
    f[FLAG_Z] = zero;
    f[FLAG_C] = carry;
    f[FLAG_V] = ovf;
    return f;
  endfunction

  // True for the multi-bit shifts whose amount comes from the bus
  function automatic logic isMultiShift(input logic [3:0] op);
    return (op == OP_SHLN) || (op == OP_SHRN);
  endfunction

endpackage

// File: rtl/alu_seq_mul_shift_add.sv
// alu_seq_mul_shift_add
//   Iterative unsigned shift-add multiplier. A start pulse loads the operands;
//   each following clock performs one shift-add step. After CYCLES steps the
//   full 2*WIDTH-bit product is held on o_product until the next start.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          load operands and begin a multiplication
//   i_a, i_b         unsigned operands
//   o_done           high during the cycle whose clock edge performs the last step
//   o_product        accumulated product (complete after the o_done edge)
module alu_seq_mul_shift_add
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int CYCLES = DATA_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(CYCLES);

  logic               r_running;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               w_last;

  // o_done is combinational so the controlling FSM can leave its iterate
  // state on the same edge that performs the final step
  assign w_last    = r_running && (r_cnt == CNT_W'(CYCLES - 1));
  assign o_done    = w_last;
  assign o_product = r_acc;

  // Shift-add datapath: the multiplicand walks left while the multiplier
  // walks right, and its low bit decides whether this step adds
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_running <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
    end else if (i_start) begin
      r_running <= 1'b1;
      r_cnt     <= '0;
      r_mcand   <= {{WIDTH{1'b0}}, i_a};
      r_mplier  <= i_b;
      r_acc     <= '0;
    end else if (r_running) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   16-bit ALU stage upstream of the Z register. Operand A comes from the Y
//   register, operand B from the internal bus. Logic/add ops finish in one
//   edge; MUL and multi-bit shifts iterate one step per clock, reporting
//   progress with busy and completion with a one-cycle done pulse.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_a_in, i_b_in   operands A and B
//   i_op             opcode, sampled with i_start
//   i_start          request, accepted only in IDLE (including the done cycle)
//   o_from_ALU       registered result, latched by Z when Z_in is high
//   o_busy           high while an iterative op is running
//   o_done           one-cycle pulse when o_from_ALU/o_flags update
//   o_flags          {N,Z,C,V} registered with the result
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic [3:0]       i_op,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_from_ALU,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_flags
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  state_e               r_state;
  state_e               w_nextState;
  logic [3:0]           r_op;
  logic [SHAMT_W-1:0]   r_amount;
  logic [CNT_W-1:0]     r_iterCnt;
  logic [WIDTH-1:0]     r_shVal;
  logic                 r_shCarry;
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_flags;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_goIter;
  logic                 w_mulStart;
  logic                 w_mulDone;
  logic                 w_shiftLast;
  logic [SHAMT_W-1:0]   w_amount;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_scResult;
  logic                 w_scCarry;
  logic                 w_scOvf;
  logic [WIDTH-1:0]     w_finResult;
  logic                 w_finCarry;
  logic [2*WIDTH-1:0]   w_product;

  assign o_from_ALU = r_result;
  assign o_flags    = r_flags;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

  // Requests are only honoured in IDLE; the done cycle is also IDLE, which is
  // what allows back-to-back operations
  assign w_amount    = i_b_in[SHAMT_W-1:0];
  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_goIter    = w_accept && ((i_op == OP_MUL) ||
                                    (isMultiShift(i_op) && (w_amount != '0)));
  assign w_mulStart  = w_accept && (i_op == OP_MUL);
  assign w_shiftLast = (r_iterCnt + CNT_W'(1)) == CNT_W'(r_amount);

  alu_seq_mul_shift_add #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_mulStart),
    .i_a       (i_a_in),
    .i_b       (i_b_in),
    .o_done    (w_mulDone),
    .o_product (w_product)
  );

  // Single-cycle result and flags straight from the live operands. The carry
  // and borrow come from the extra top bit of a zero-extended add/subtract.
  // Multi-bit shifts only land here with a zero amount, where they pass A.
  always_comb begin
    w_sum      = {1'b0, i_a_in} + {1'b0, i_b_in};
    w_diff     = {1'b0, i_a_in} - {1'b0, i_b_in};
    w_scResult = i_b_in;
    w_scCarry  = 1'b0;
    w_scOvf    = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_scResult = w_sum[WIDTH-1:0];
        w_scCarry  = w_sum[WIDTH];
        w_scOvf    = (i_a_in[WIDTH-1] == i_b_in[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != i_a_in[WIDTH-1]);
      end
      OP_SUB: begin
        w_scResult = w_diff[WIDTH-1:0];
        w_scCarry  = w_diff[WIDTH];
        w_scOvf    = (i_a_in[WIDTH-1] != i_b_in[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != i_a_in[WIDTH-1]);
      end
      OP_AND:  w_scResult = i_a_in & i_b_in;
      OP_OR:   w_scResult = i_a_in | i_b_in;
      OP_XOR:  w_scResult = i_a_in ^ i_b_in;
      OP_NOT:  w_scResult = ~i_a_in;
      OP_SHL1: begin
        w_scResult = i_a_in << 1;
        w_scCarry  = i_a_in[WIDTH-1];
      end
      OP_SHR1: begin
        w_scResult = i_a_in >> 1;
        w_scCarry  = i_a_in[0];
      end
      OP_SHLN, OP_SHRN: w_scResult = i_a_in;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the completion value used in FINISH. MUL leaves
  // ITER on the multiplier's last-step indication; shifts use the local count.
  always_comb begin
    w_nextState = r_state;
    w_finResult = r_shVal;
    w_finCarry  = r_shCarry;
    if (r_op == OP_MUL) begin
      w_finResult = w_product[WIDTH-1:0];
      w_finCarry  = |w_product[2*WIDTH-1:WIDTH];
    end
    case (r_state)
      ST_IDLE: begin
        if (w_goIter) begin
          w_nextState = ST_ITER;
        end
      end
      ST_ITER: begin
        if ((r_op == OP_MUL) ? w_mulDone : w_shiftLast) begin
          w_nextState = ST_FINISH;
        end
      end
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Datapath registers: operand capture on accept, one shift per ITER edge,
  // result/flag write-back either on accept (single-cycle) or in FINISH
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op      <= '0;
      r_amount  <= '0;
      r_iterCnt <= '0;
      r_shVal   <= '0;
      r_shCarry <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= i_op;
            r_iterCnt <= '0;
            if (w_goIter) begin
              r_busy    <= 1'b1;
              r_shVal   <= i_a_in;
              r_shCarry <= 1'b0;
              r_amount  <= w_amount;
            end else begin
              r_result <= w_scResult;
              r_flags  <= makeFlags(w_scResult[WIDTH-1], w_scResult == '0,
                                    w_scCarry, w_scOvf);
              r_done   <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          r_iterCnt <= r_iterCnt + CNT_W'(1);
          if (r_op == OP_SHLN) begin
            r_shCarry <= r_shVal[WIDTH-1];
            r_shVal   <= r_shVal << 1;
          end else if (r_op == OP_SHRN) begin
            r_shCarry <= r_shVal[0];
            r_shVal   <= r_shVal >> 1;
          end
        end
        ST_FINISH: begin
          r_result <= w_finResult;
          r_flags  <= makeFlags(w_finResult[WIDTH-1], w_finResult == '0,
                                w_finCarry, 1'b0);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Self-checking bench for alu_seq: reset state, a table of directed vectors
//   issued back-to-back, hand-written multi-cycle sequences (ignored start
//   while busy, reset in the middle of a MUL) and randomised operations
//   compared against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int LAT_LIMIT = 40;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    int          lat;
  } model_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_a_in;
  logic [15:0] i_b_in;
  logic [3:0]  i_op;
  logic        i_start;
  logic [15:0] o_from_ALU;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_flags;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  alu_seq dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_a_in     (i_a_in),
    .i_b_in     (i_b_in),
    .i_op       (i_op),
    .i_start    (i_start),
    .o_from_ALU (o_from_ALU),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_flags    (o_flags)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge
  always #5 i_clk = ~i_clk;

  // Hard stop in case something upstream ever blocks
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issues one request from a falling edge and waits for done. Latency is the
  // number of rising edges after the accepting edge until done is visible.
  // Operands are scrambled after acceptance to show they are not re-read.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input bit expIter,
                               output logic [15:0] res, output logic [3:0] flg,
                               output int lat, output bit busyOk);
    i_op    = op;
    i_a_in  = a;
    i_b_in  = b;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    i_op    = 4'($urandom);
    i_a_in  = 16'($urandom);
    i_b_in  = 16'($urandom);
    lat     = 0;
    busyOk  = 1'b1;
    while (!o_done && lat < LAT_LIMIT) begin
      if (o_busy !== expIter) busyOk = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      lat++;
    end
    checkOutput($sformatf("done seen op=%0d", op), 32'(o_done), 32'd1);
    if (o_busy !== 1'b0) busyOk = 1'b0;
    res = o_from_ALU;
    flg = o_flags;
  endtask

  task automatic addVec(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] res,
                        input logic [3:0] flg, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flags = flg; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Reference model: plain integer arithmetic on the opcode rules
  function automatic model_t refModel(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    model_t      m;
    int unsigned ua, ub, full, res;
    int          sa, sb, sres, amt;
    bit          c, v;
    logic [15:0] r16;
    ua = 32'(a); ub = 32'(b);
    sa = $signed(a); sb = $signed(b);
    amt = int'(ub & 32'd15);
    c = 1'b0; v = 1'b0; res = ub; m.lat = 0;
    case (op)
      4'd0: begin
        full = ua + ub; res = full & 32'hFFFF; c = (full > 32'd65535);
        sres = sa + sb; v = (sres > 32767) || (sres < -32768);
      end
      4'd1: begin
        res = (ua - ub) & 32'hFFFF; c = (ua < ub);
        sres = sa - sb; v = (sres > 32767) || (sres < -32768);
      end
      4'd2: res = ua & ub;
      4'd3: res = ua | ub;
      4'd4: res = ua ^ ub;
      4'd5: res = (~ua) & 32'hFFFF;
      4'd6: begin res = (ua << 1) & 32'hFFFF; c = ((ua >> 15) & 1) != 0; end
      4'd7: begin res = ua >> 1; c = (ua & 1) != 0; end
      4'd8: begin
        res = (ua << amt) & 32'hFFFF;
        if (amt > 0) begin c = ((ua >> (16 - amt)) & 1) != 0; m.lat = amt + 1; end
      end
      4'd9: begin
        res = ua >> amt;
        if (amt > 0) begin c = ((ua >> (amt - 1)) & 1) != 0; m.lat = amt + 1; end
      end
      4'd10: begin
        full = ua * ub; res = full & 32'hFFFF; c = (full >= 32'd65536); m.lat = 17;
      end
      default: res = ub;
    endcase
    r16     = res[15:0];
    m.res   = r16;
    m.flags = {r16[15], (r16 == 16'h0000), c, v};
    return m;
  endfunction

  initial begin
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    int          doneCnt;
    bit          busyOk;
    model_t      m;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_a_in = '0; i_b_in = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    checkOutput("reset from_ALU", 32'(o_from_ALU), 32'd0);
    checkOutput("reset flags", 32'(o_flags), 32'd0);
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset done", 32'(o_done), 32'd0);

    // op, a, b, result, {N,Z,C,V}, latency
    addVec(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 0);
    addVec(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 0);
    addVec(OP_SUB,  16'h0005, 16'h0005, 16'h0000, 4'b0100, 0);
    addVec(OP_MUL,  16'h0012, 16'h0034, 16'h03A8, 4'b0000, 17);
    addVec(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b0110, 17);
    addVec(OP_SHLN, 16'hABAA, 16'h0004, 16'hBAA0, 4'b1000, 5);
    addVec(OP_SHRN, 16'hABAA, 16'h0001, 16'h55D5, 4'b0000, 2);
    addVec(OP_SHLN, 16'hABAA, 16'h0000, 16'hABAA, 4'b1000, 0);
    addVec(OP_AND,  16'hFF00, 16'h0F0F, 16'h0F00, 4'b0000, 0);
    addVec(OP_OR,   16'h0000, 16'h0000, 16'h0000, 4'b0100, 0);
    addVec(OP_XOR,  16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000, 0);
    addVec(OP_NOT,  16'h00FF, 16'h1234, 16'hFF00, 4'b1000, 0);
    addVec(OP_SHL1, 16'h8001, 16'h0000, 16'h0002, 4'b0010, 0);
    addVec(OP_SHR1, 16'h0001, 16'h0000, 16'h0000, 4'b0110, 0);
    addVec(OP_PASSB,16'h5555, 16'h1234, 16'h1234, 4'b0000, 0);
    addVec(4'd13,   16'h5555, 16'h8000, 16'h8000, 4'b1000, 0);
    addVec(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 0);
    addVec(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 0);
    addVec(OP_SHRN, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 16);
    addVec(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 17);

    // Each vector starts in the done cycle of the previous one
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat != 0,
                    res, flg, lat, busyOk);
      checkOutput($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].res));
      checkOutput($sformatf("vec%0d flags", i), 32'(flg), 32'(vecs[i].flags));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d busy", i), 32'(busyOk), 32'd1);
    end

    // MUL with an ADD request arriving at iteration 5: it must be dropped
    @(negedge i_clk);
    i_op = OP_MUL; i_a_in = 16'h0012; i_b_in = 16'h0034; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 0;
    repeat (4) begin @(posedge i_clk); @(negedge i_clk); lat++; end
    i_start = 1'b1; i_op = OP_ADD; i_a_in = 16'h0001; i_b_in = 16'h0001;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    lat++;
    while (!o_done && lat < LAT_LIMIT) begin
      @(posedge i_clk); @(negedge i_clk); lat++;
    end
    checkOutput("ignored start latency", 32'(lat), 32'd17);
    checkOutput("ignored start result", 32'(o_from_ALU), 32'h03A8);
    checkOutput("ignored start flags", 32'(o_flags), 32'h0);
    doneCnt = 0;
    repeat (6) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_done) doneCnt++;
    end
    checkOutput("no extra done", 32'(doneCnt), 32'd0);
    checkOutput("result held", 32'(o_from_ALU), 32'h03A8);

    // Reset asserted at iteration 8 of a MUL
    i_op = OP_MUL; i_a_in = 16'h0100; i_b_in = 16'h0100; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (7) begin @(posedge i_clk); @(negedge i_clk); end
    checkOutput("busy before reset", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    checkOutput("midop reset busy", 32'(o_busy), 32'd0);
    checkOutput("midop reset done", 32'(o_done), 32'd0);
    checkOutput("midop reset from_ALU", 32'(o_from_ALU), 32'd0);
    checkOutput("midop reset flags", 32'(o_flags), 32'd0);
    applyStimulus(OP_ADD, 16'h0001, 16'h0001, 1'b0, res, flg, lat, busyOk);
    checkOutput("post reset add result", 32'(res), 32'h0002);
    checkOutput("post reset add flags", 32'(flg), 32'h0);
    checkOutput("post reset add latency", 32'(lat), 32'd0);
    checkOutput("post reset add busy", 32'(busyOk), 32'd1);

    // Randomised operations against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      m   = refModel(rop, ra, rb);
      applyStimulus(rop, ra, rb, m.lat != 0, res, flg, lat, busyOk);
      checkOutput($sformatf("rnd%0d op%0d result", i, rop), 32'(res), 32'(m.res));
      checkOutput($sformatf("rnd%0d op%0d flags", i, rop), 32'(flg), 32'(m.flags));
      checkOutput($sformatf("rnd%0d op%0d latency", i, rop), 32'(lat), 32'(m.lat));
      checkOutput($sformatf("rnd%0d op%0d busy", i, rop), 32'(busyOk), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
